// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker
//   Read-side consumer for FIFO loopback checks, clocked in the FIFO read domain.
//   On start it drains i_count words. Each word is compared against an
//   incrementing pattern i_base, i_base+1, ... The run reports pass/fail, the
//   error count and the index of the first failing word.
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for i_start; results of the previous run are held
// RUN    | issuing reads while words remain; idle counter watches empty
// DRAIN  | no more reads; the last outstanding word is checked
// DONE   | one-cycle o_done pulse, then back to IDLE
//
// Ports
//   i_rd_clk, i_rst_n   : read clock, async active-low reset
//   i_start             : run request, honoured only in IDLE
//   i_base, i_count     : first expected word and number of words, sampled on start
//   i_empty, i_dout     : FIFO empty flag and read data (data valid the cycle after o_rd_en)
//   o_rd_en             : FIFO read strobe
//   o_busy, o_done      : run in progress / end-of-run pulse
//   o_pass, o_timeout   : run result flags, held until next start
//   o_err_cnt           : mismatching words (saturating)
//   o_rcv_cnt           : words received and checked
//   o_first_err_idx     : index of first mismatch, all-ones if none
module fifo_rd_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_base,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic                  o_rd_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [CNT_WIDTH-1:0]  o_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_rcv_cnt,
  output logic [CNT_WIDTH-1:0]  o_first_err_idx
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [IDLE_W-1:0]     r_idle_cnt;
  logic                  r_vld;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [CNT_WIDTH-1:0]  r_rcv_cnt;
  logic [CNT_WIDTH-1:0]  r_first_err_idx;
  logic                  r_pass;
  logic                  r_timeout;

  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_exp;
  logic                  w_mismatch;
  logic [CNT_WIDTH-1:0]  w_err_nxt;
  logic                  w_timeout_hit;

  // Expected word wraps modulo 2^DATA_WIDTH regardless of counter width.
  assign w_exp      = r_base + DATA_WIDTH'(r_rcv_cnt);
  assign w_mismatch = r_vld && (i_dout != w_exp);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + CNT_WIDTH'(1) : r_err_cnt;

  // The counter reaches TIMEOUT on this edge.
  assign w_timeout_hit = (r_state == S_RUN) && i_empty &&
                         (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_rd_en = !i_empty && (r_issued < r_count);
        if (w_rd_en && ((r_issued + CNT_WIDTH'(1)) == r_count)) w_state_nxt = S_DRAIN;
        else if (w_timeout_hit)                                 w_state_nxt = S_DRAIN;
      end
      // At most one word is in flight after the last read, and it is checked
      // during this single DRAIN cycle.
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base          <= '0;
      r_count         <= '0;
      r_issued        <= '0;
      r_idle_cnt      <= '0;
      r_vld           <= 1'b0;
      r_err_cnt       <= '0;
      r_rcv_cnt       <= '0;
      r_first_err_idx <= '1;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_vld <= w_rd_en;
      if ((r_state == S_IDLE) && i_start) begin
        r_base          <= i_base;
        r_count         <= i_count;
        r_issued        <= '0;
        r_idle_cnt      <= '0;
        r_err_cnt       <= '0;
        r_rcv_cnt       <= '0;
        r_first_err_idx <= '1;
        r_timeout       <= 1'b0;
        // A zero-length run goes straight to DONE and passes trivially.
        r_pass          <= (i_count == '0);
      end else begin
        if (w_rd_en) r_issued <= r_issued + CNT_WIDTH'(1);
        if (r_state == S_RUN) begin
          if (w_rd_en)      r_idle_cnt <= '0;
          else if (i_empty) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
        if (w_timeout_hit) r_timeout <= 1'b1;
        if (r_vld) begin
          r_rcv_cnt <= r_rcv_cnt + CNT_WIDTH'(1);
          r_err_cnt <= w_err_nxt;
          if (w_mismatch && (r_first_err_idx == '1)) r_first_err_idx <= r_rcv_cnt;
        end
        // Resolve pass on entry to DONE so it is valid in the done cycle,
        // including a mismatch on the final word checked in DRAIN.
        if (r_state == S_DRAIN) r_pass <= (w_err_nxt == '0) && !r_timeout;
      end
    end
  end

  assign o_rd_en         = w_rd_en;
  assign o_busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done          = (r_state == S_DONE);
  assign o_pass          = r_pass;
  assign o_timeout       = r_timeout;
  assign o_err_cnt       = r_err_cnt;
  assign o_rcv_cnt       = r_rcv_cnt;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_fifo_rd_checker.sv
module tb_fifo_rd_checker;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       i_rst_n, i_start, i_empty;
  logic [7:0] i_base, i_count, i_dout;
  logic       o_rd_en, o_busy, o_done, o_pass, o_timeout;
  logic [7:0] o_err_cnt, o_rcv_cnt, o_first_err_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  int         g_stall_pct = 0;
  logic [7:0] popped = 8'h00;
  bit         rd_seen, done_seen, busy_seen, empty_seen, pass_seen;

  always #5 clk = ~clk;

  fifo_rd_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8), .TIMEOUT(TO)) dut (
    .i_rd_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base(i_base),
    .i_count(i_count), .i_empty(i_empty), .i_dout(i_dout), .o_rd_en(o_rd_en),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_err_cnt(o_err_cnt), .o_rcv_cnt(o_rcv_cnt), .o_first_err_idx(o_first_err_idx)
  );

  // Behavioural FIFO: snapshot outputs mid-cycle, pop on a read, present the
  // popped word in the following cycle; garbage on dout otherwise.
  task automatic step();
    @(negedge clk);
    rd_seen    = o_rd_en;
    done_seen  = o_done;
    busy_seen  = o_busy;
    pass_seen  = o_pass;
    empty_seen = i_empty;
    if (rd_seen && q.size() > 0) popped = q.pop_front();
    @(posedge clk);
    #1;
    i_dout  = rd_seen ? popped : 8'($urandom);
    i_empty = (q.size() == 0) || (int'($urandom_range(0, 99)) < g_stall_pct);
  endtask

  // Model: the checker reads min(count, available) words; a short supply
  // times out. Errors are counted against base+i mod 256.
  task automatic run_check(input string name, input logic [7:0] b, input logic [7:0] c,
                           input bit poke_busy);
    int n_avail, exp_rcv, exp_err, exp_first, t, n_rd, last_rd, done_t;
    bit exp_to, exp_pass, exp_rd, poked;
    n_avail = q.size();
    exp_rcv = (n_avail < int'(c)) ? n_avail : int'(c);
    exp_to  = n_avail < int'(c);
    exp_err = 0;
    exp_first = 255;
    for (int i = 0; i < exp_rcv; i++) begin
      if (q[i] != 8'(int'(b) + i)) begin
        if (exp_err < 255) exp_err++;
        if (exp_first == 255) exp_first = i;
      end
    end
    exp_pass = !exp_to && (exp_err == 0);

    i_empty = (q.size() == 0);
    i_start = 1'b1; i_base = b; i_count = c;
    step();
    i_start = 1'b0;
    t = 0; n_rd = 0; last_rd = -1; done_t = -1; poked = 0;
    while (t < 400) begin
      exp_rd = (t >= 1) && (n_rd < int'(c)) && !empty_seen;
      n_tests++;
      if (rd_seen !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rd_en t=%0d: got %0b want %0b (empty=%0b)", name, t, rd_seen, exp_rd, empty_seen);
      end
      if (rd_seen && empty_seen) begin
        n_fail++;
        $display("FAIL %s rd_en_while_empty t=%0d: got 1 want 0", name, t);
      end
      if (rd_seen) begin n_rd++; last_rd = t; end
      if (done_seen) begin done_t = t; break; end
      if (poked) i_start = 1'b0;
      if (poke_busy && !poked && busy_seen && t >= 2) begin
        i_start = 1'b1; i_base = ~b; i_count = c + 8'd3; poked = 1;
      end
      step();
      t++;
    end
    i_start = 1'b0;
    n_tests++;
    if (done_t < 0) begin n_fail++; $display("FAIL %s done_seen: got none want pulse within 400 cycles", name); end
    n_tests++;
    if (n_rd != exp_rcv) begin n_fail++; $display("FAIL %s reads: got %0d want %0d", name, n_rd, exp_rcv); end
    n_tests++;
    if (pass_seen !== exp_pass) begin n_fail++; $display("FAIL %s pass_at_done: got %0b want %0b", name, pass_seen, exp_pass); end
    n_tests++;
    if (int'(c) == 0) begin
      if (done_t != 1) begin n_fail++; $display("FAIL %s done_latency: got %0d want 1", name, done_t); end
    end else begin
      if (done_t - last_rd != (exp_to ? TO + 2 : 2)) begin
        n_fail++;
        $display("FAIL %s done_latency: got %0d want %0d", name, done_t - last_rd, exp_to ? TO + 2 : 2);
      end
    end
    // now one cycle past done: results must be held
    n_tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL %s post_done: got done=%0b busy=%0b want 0 0", name, o_done, o_busy); end
    n_tests++;
    if (o_rcv_cnt !== 8'(exp_rcv)) begin n_fail++; $display("FAIL %s rcv_cnt: got %0d want %0d", name, o_rcv_cnt, exp_rcv); end
    n_tests++;
    if (o_err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, o_err_cnt, exp_err); end
    n_tests++;
    if (o_first_err_idx !== 8'(exp_first)) begin n_fail++; $display("FAIL %s first_err_idx: got %0d want %0d", name, o_first_err_idx, exp_first); end
    n_tests++;
    if (o_pass !== exp_pass) begin n_fail++; $display("FAIL %s pass: got %0b want %0b", name, o_pass, exp_pass); end
    n_tests++;
    if (o_timeout !== exp_to) begin n_fail++; $display("FAIL %s timeout: got %0b want %0b", name, o_timeout, exp_to); end
    q.delete();
    i_empty = 1'b1;
    step();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_start = 1'b0; i_base = 8'h00; i_count = 8'h00;
    i_empty = 1'b1; i_dout = 8'h00;
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({o_rd_en, o_busy, o_done, o_pass, o_timeout} !== 5'b0 || o_err_cnt !== 8'h00 ||
        o_rcv_cnt !== 8'h00 || o_first_err_idx !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_values: got rd=%0b busy=%0b done=%0b pass=%0b to=%0b err=%0d rcv=%0d first=%0h want 0 0 0 0 0 0 0 ff",
               o_rd_en, o_busy, o_done, o_pass, o_timeout, o_err_cnt, o_rcv_cnt, o_first_err_idx);
    end
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 14; i++) q.push_back(8'(8'hA0 + i));
    run_check("basic", 8'hA0, 8'd14, 0);
  endtask

  task automatic test_mismatch();
    q = '{8'h10, 8'h11, 8'h99, 8'h13, 8'h14, 8'h15};
    run_check("mismatch", 8'h10, 8'd6, 0);
  endtask

  task automatic test_wrap();
    q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_check("wrap", 8'hFE, 8'd4, 0);
  endtask

  task automatic test_zero_count();
    q = '{8'h55, 8'h56};
    run_check("zero_count", 8'h55, 8'd0, 0);
  endtask

  task automatic test_timeout();
    q = '{8'h20, 8'h21, 8'h22};
    run_check("timeout", 8'h20, 8'd5, 0);
  endtask

  task automatic test_random_stalls();
    logic [7:0] b;
    int c;
    g_stall_pct = 30;
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      c = int'($urandom_range(1, 20));
      for (int i = 0; i < c; i++) begin
        if ($urandom_range(0, 5) == 0) q.push_back(8'(int'(b) + i) ^ 8'(int'($urandom_range(1, 255))));
        else                           q.push_back(8'(int'(b) + i));
      end
      run_check($sformatf("random%0d", r), b, 8'(c), 1);
    end
    g_stall_pct = 0;
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h30 + i));
    q[1] = 8'h00;  // leave an error behind to prove reset clears it
    i_empty = 1'b0;
    i_start = 1'b1; i_base = 8'h30; i_count = 8'd10;
    step();
    i_start = 1'b0;
    repeat (5) step();
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %0b want 1", o_busy); end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_rd_en, o_busy, o_done, o_pass, o_timeout} !== 5'b0 || o_err_cnt !== 8'h00 ||
        o_rcv_cnt !== 8'h00 || o_first_err_idx !== 8'hFF) begin
      n_fail++;
      $display("FAIL midrun_reset: got rd=%0b busy=%0b done=%0b pass=%0b to=%0b err=%0d rcv=%0d first=%0h want 0 0 0 0 0 0 0 ff",
               o_rd_en, o_busy, o_done, o_pass, o_timeout, o_err_cnt, o_rcv_cnt, o_first_err_idx);
    end
    q.delete();
    i_empty = 1'b1;
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) q.push_back(8'(8'h40 + i));
    run_check("after_reset", 8'h40, 8'd5, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_wrap();
    test_zero_count();
    test_timeout();
    test_random_stalls();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
# fifo_rd_checker

Self-checking read-side consumer for the async FIFO's read port, clocked in the read domain. On a start command it drains a programmed number of words and compares each against an incrementing pattern (base, base+1, …). It reports the pass/fail result, error count and first failing index. It is the synthesizable counterpart of the write-side pattern generator and is used for on-chip FIFO loopback checks.

## Interface
- DATA_WIDTH, default 8: FIFO word width.
- CNT_WIDTH, default 8: width of the word-count and index counters.
- TIMEOUT, default 64: consecutive `rd_clk` cycles with `empty` high, while words are still outstanding, that abort a run.
- rd_clk, in, 1: sole clock, the FIFO read clock.
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: single-cycle run request; ignored unless in IDLE.
- base, in, DATA_WIDTH: expected value of the first word; sampled on start.
- count, in, CNT_WIDTH: number of words to drain; sampled on start.
- empty, in, 1: FIFO empty flag, read-domain synchronized.
- dout, in, DATA_WIDTH: FIFO read data; valid the cycle after a `rd_en` cycle.
- rd_en, out, 1: FIFO read strobe.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: one-cycle pulse at run end.
- pass, out, 1: run ended with err_cnt == 0 and no timeout; held until next start.
- timeout, out, 1: run aborted by timeout; held until next start.
- err_cnt, out, CNT_WIDTH: mismatching words this run; saturates at all-ones.
- rcv_cnt, out, CNT_WIDTH: words received and checked this run.
- first_err_idx, out, CNT_WIDTH: index of the first mismatch; all-ones if none.

## Operation
- Reset values: rd_en 0, busy 0, done 0, pass 0, timeout 0, err_cnt 0, rcv_cnt 0, first_err_idx all-ones, state IDLE.
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On start: latch base and count, clear err_cnt, rcv_cnt, pass and timeout, and set first_err_idx to all-ones.
  - If count == 0, go to DONE; otherwise go to RUN.
- **RUN**
  - Drive rd_en = !empty && (issued < count) combinationally from registered state.
  - Each rd_en cycle increments `issued`.
  - When issued reaches count, go to DRAIN.
- **DRAIN**
  - rd_en is 0.
  - Wait for the last outstanding word to be checked, then go to DONE.
- **Checking** (active in both RUN and DRAIN)
  - A registered flag `vld` equals the previous cycle's rd_en.
  - When vld is high, compare dout with (base + rcv_cnt) mod 2^DATA_WIDTH.
  - On mismatch, increment err_cnt (saturating). If first_err_idx is still all-ones, load it with rcv_cnt.
  - Every checked word increments rcv_cnt.
- **DONE**
  - Assert done for one cycle.
  - Set pass = (err_cnt == 0) && !timeout.
  - Return to IDLE.
- **Timeout**
  - An idle counter increments each RUN cycle with empty high and clears on any rd_en.
  - When the counter reaches TIMEOUT: set timeout, go to DRAIN, then DONE; pass = 0.
- **Boundary conditions**
  - Expected value wraps naturally (base FF → 00).
  - start while busy is ignored.
  - rst_n low mid-run returns all outputs to reset values immediately; a partial run leaves no residue.
  - rd_en is never asserted while empty = 1.

## Timing
- rd_en is combinational from state, counters and empty. It must not depend on start in the same cycle.
- First rd_en can occur 1 cycle after start, provided empty = 0.
- Check latency: a word read in cycle N is compared and counted in cycle N+1.
- Throughput: one word per cycle while empty = 0.
- done occurs 2 cycles after the final rd_en, or 1 cycle after start when count == 0.
- err_cnt, rcv_cnt and first_err_idx are registered and stable from the done cycle until the next start.

## Test plan
- Prefill 14 words A0..AD; start with base=A0, count=14 → 14 rd_en cycles; done with pass=1, err_cnt=0, rcv_cnt=14, first_err_idx=FF.
- Prefill words 10,11,99,13,14,15; start with base=10, count=6 → err_cnt=1, first_err_idx=2, pass=0, rcv_cnt=6.
- Prefill FE,FF,00,01; start with base=FE, count=4 → pass=1 (wrap-around).
- Start with count=0 → done 1 cycle later with pass=1, rd_en never asserted.
- Prefill 3 of 5 words; start with base=20, count=5; TIMEOUT=64 → timeout=1, pass=0, rcv_cnt=3, done about 66 cycles after the last read.
- Drive empty=0 continuously and toggle empty mid-stream; assert rst_n=0 mid-run and pulse start while busy → rd_en follows !empty with no read on empty; on reset all outputs return to reset values; start while busy is ignored.
